sobel_frame_sched: RTL and testbench

Frame sequencer for the Sobel edge pipeline. On a start request it walks one image frame in raster order and issues three row-aligned pixel read addresses per cycle to the image memory feeding the 3x3 window. It tracks the window-datapath latency and emits a write-back strobe, address and border flag for each result pixel, then signals frame completion. It sits between the system control logic and the image-read/window/masking datapath.

---
 rtl/sobel_frame_sched_if.sv | 29 ++
 rtl/sobel_frame_sched.sv | 168 ++++++++++++++++
 tb/tb_sobel_frame_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_sched_if.sv
// Control and address bundle between the Sobel frame sequencer and its
// controller/image-memory/write-back neighbours.
interface sobel_frame_sched_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_t;
  logic [ADDR_W-1:0] rd_addr_m;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_border;

  modport master (
    input  start, stall,
    output busy, done, rd_en, rd_addr_t, rd_addr_m, rd_addr_b,
           wr_valid, wr_addr, wr_border
  );

  modport slave (
    output start, stall,
    input  busy, done, rd_en, rd_addr_t, rd_addr_m, rd_addr_b,
           wr_valid, wr_addr, wr_border
  );
endinterface

// File: rtl/sobel_frame_sched.sv
// Raster-order frame walker for the 3x3 Sobel window: issues three row reads per
// fetch and replays each completed window as a write-back token LAT cycles later.
module sobel_frame_sched #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_frame_sched_if.master   bus
);
  localparam int R_W  = $clog2(IMG_H);
  localparam int F_W  = $clog2(IMG_W + 1);
  localparam int FL_W = $clog2(LAT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [F_W-1:0]    f_q, f_d;
  logic [FL_W-1:0]   fl_q, fl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_t_q, addr_t_d, addr_m_q, addr_m_d, addr_b_q, addr_b_d;
  logic              tok_vld_q, tok_vld_d;
  logic [ADDR_W-1:0] tok_addr_q, tok_addr_d;
  logic              tok_brd_q, tok_brd_d;
  logic              dly_vld_q  [LAT];
  logic              dly_vld_d  [LAT];
  logic [ADDR_W-1:0] dly_addr_q [LAT];
  logic [ADDR_W-1:0] dly_addr_d [LAT];
  logic              dly_brd_q  [LAT];
  logic              dly_brd_d  [LAT];

  logic              last_f, last_r;
  logic [ADDR_W-1:0] fc, row_m, row_t, row_b;

  // Fetch geometry: the prefetch column reuses the last real column, edge rows replicate.
  always_comb begin
    last_f = (f_q == F_W'(IMG_W));
    last_r = (r_q == R_W'(IMG_H - 1));
    fc     = last_f ? ADDR_W'(IMG_W - 1) : ADDR_W'(f_q);
    row_m  = ADDR_W'(r_q) * ADDR_W'(IMG_W);
    row_t  = (r_q == '0) ? row_m : row_m - ADDR_W'(IMG_W);
    row_b  = last_r ? row_m : row_m + ADDR_W'(IMG_W);
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    f_d        = f_q;
    fl_d       = fl_q;
    busy_d     = (state_q != IDLE);
    done_d     = (state_q == DONE);
    rd_en_d    = 1'b0;
    addr_t_d   = addr_t_q;
    addr_m_d   = addr_m_q;
    addr_b_d   = addr_b_q;
    tok_vld_d  = 1'b0;
    tok_addr_d = '0;
    tok_brd_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          r_d     = '0;
          f_d     = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          rd_en_d  = 1'b1;
          addr_t_d = row_t + fc;
          addr_m_d = row_m + fc;
          addr_b_d = row_b + fc;
          // Column f completes the window centred one column to the left.
          if (f_q != '0) begin
            tok_vld_d  = 1'b1;
            tok_addr_d = row_m + ADDR_W'(f_q) - ADDR_W'(1);
            tok_brd_d  = (r_q == '0) || last_r || (f_q == F_W'(1)) || last_f;
          end
          if (last_f) begin
            f_d = '0;
            if (last_r) begin
              state_d = FLUSH;
              r_d     = '0;
              fl_d    = '0;
            end else begin
              r_d = r_q + R_W'(1);
            end
          end else begin
            f_d = f_q + F_W'(1);
          end
        end
      end
      FLUSH: begin
        if (fl_q == FL_W'(LAT - 1)) state_d = DONE;
        else                        fl_d    = fl_q + FL_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Token delay line: mirrors the window datapath latency, shifts unconditionally.
  always_comb begin
    dly_vld_d[0]  = tok_vld_q;
    dly_addr_d[0] = tok_addr_q;
    dly_brd_d[0]  = tok_brd_q;
    for (int i = 1; i < LAT; i++) begin
      dly_vld_d[i]  = dly_vld_q[i-1];
      dly_addr_d[i] = dly_addr_q[i-1];
      dly_brd_d[i]  = dly_brd_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      f_q        <= '0;
      fl_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_t_q   <= '0;
      addr_m_q   <= '0;
      addr_b_q   <= '0;
      tok_vld_q  <= 1'b0;
      tok_addr_q <= '0;
      tok_brd_q  <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        dly_vld_q[i]  <= 1'b0;
        dly_addr_q[i] <= '0;
        dly_brd_q[i]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      f_q        <= f_d;
      fl_q       <= fl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      addr_t_q   <= addr_t_d;
      addr_m_q   <= addr_m_d;
      addr_b_q   <= addr_b_d;
      tok_vld_q  <= tok_vld_d;
      tok_addr_q <= tok_addr_d;
      tok_brd_q  <= tok_brd_d;
      dly_vld_q  <= dly_vld_d;
      dly_addr_q <= dly_addr_d;
      dly_brd_q  <= dly_brd_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_t = addr_t_q;
  assign bus.rd_addr_m = addr_m_q;
  assign bus.rd_addr_b = addr_b_q;
  assign bus.wr_valid  = dly_vld_q[LAT-1];
  assign bus.wr_addr   = dly_addr_q[LAT-1];
  assign bus.wr_border = dly_brd_q[LAT-1];
endmodule

// File: tb/tb_sobel_frame_sched.sv
// Directed bench for sobel_frame_sched on a 4x3 frame with LAT=2; cycle k is the
// interval following the k-th rising edge after the start edge.
module tb_sobel_frame_sched;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 8;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_frame_sched_if #(.ADDR_W(AW)) bus ();

  sobel_frame_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int rd_cnt, rd_first, rd_last, done_cnt, busy_first, busy_last, wr_cnt, wr_last, fl_cnt;
  logic prev_rd, prev_busy;
  int rd_rise[$];
  int done_log[$];
  int busy_fall[$];
  int wa_log[$];
  int wb_log[$];
  logic [11:0] brd_exp = 12'b1111_1001_1111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_cnt = 0; rd_first = 0; rd_last = 0; done_cnt = 0;
    busy_first = 0; busy_last = 0; wr_cnt = 0; wr_last = 0; fl_cnt = 0;
    rd_rise.delete(); done_log.delete(); busy_fall.delete();
    wa_log.delete(); wb_log.delete();
    prev_rd = bus.rd_en; prev_busy = bus.busy;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rd_en === 1'b1) begin
      rd_cnt++;
      if (rd_first == 0) rd_first = cyc;
      rd_last = cyc;
      if (prev_rd !== 1'b1) rd_rise.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_log.push_back(cyc);
    end
    if (bus.busy === 1'b1) begin
      if (busy_first == 0) busy_first = cyc;
      busy_last = cyc;
    end else if (prev_busy === 1'b1) begin
      busy_fall.push_back(cyc);
    end
    if (bus.busy === 1'b1 && bus.rd_en !== 1'b1 && bus.done !== 1'b1) fl_cnt++;
    if (bus.wr_valid === 1'b1) begin
      wr_cnt++;
      wr_last = cyc;
      wa_log.push_back(int'(bus.wr_addr));
      wb_log.push_back(int'(bus.wr_border));
    end
    prev_rd   = bus.rd_en;
    prev_busy = bus.busy;
  endtask

  task automatic start_frame(input bit hold);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    cyc = 0;
    clear_log();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_rd_t"},  bus.rd_addr_t, 0);
    chk({tag, "_rd_m"},  bus.rd_addr_m, 0);
    chk({tag, "_rd_b"},  bus.rd_addr_b, 0);
    chk({tag, "_wr_v"},  bus.wr_valid, 0);
    chk({tag, "_wr_a"},  bus.wr_addr, 0);
    chk({tag, "_wr_b"},  bus.wr_border, 0);
  endtask

  // Result stream of n pixels: addresses 0..11 per frame, interior only at 5 and 6.
  task automatic chk_seq(input string tag, input int n);
    chk({tag, "_wr_cnt"}, wa_log.size(), n);
    for (int i = 0; i < n && i < wa_log.size(); i++) begin
      chk($sformatf("%s_wr_addr%0d", tag, i), wa_log[i], i % 12);
      chk($sformatf("%s_wr_border%0d", tag, i), wb_log[i], brd_exp[i % 12]);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    rst = 1'b1;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    clear_log();
    repeat (2) cycle();
    chk("idle_busy", busy_last, 0);

    // Plain frame
    start_frame(0);
    cycle();
    chk("c1_rd_en", bus.rd_en, 1);
    chk("c1_rd_t", bus.rd_addr_t, 0);
    chk("c1_rd_m", bus.rd_addr_m, 0);
    chk("c1_rd_b", bus.rd_addr_b, 4);
    while (cyc < 15) cycle();
    chk("c15_rd_en", bus.rd_en, 1);
    chk("c15_rd_t", bus.rd_addr_t, 7);
    chk("c15_rd_m", bus.rd_addr_m, 11);
    chk("c15_rd_b", bus.rd_addr_b, 11);
    cycle();
    chk("c16_rd_en", bus.rd_en, 0);
    chk("c16_hold_m", bus.rd_addr_m, 11);
    while (cyc < 22) cycle();
    chk("f1_rd_cnt", rd_cnt, 15);
    chk("f1_rd_first", rd_first, 1);
    chk("f1_rd_last", rd_last, 15);
    chk("f1_flush_cycles", fl_cnt, 2);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_done_cyc", qget(done_log, 0), 18);
    chk("f1_busy_first", busy_first, 1);
    chk("f1_busy_last", busy_last, 18);
    chk("f1_wr_last", wr_last, 17);
    chk_seq("f1", 12);

    // Stall during RUN (edges 4-6) and during FLUSH (edges 19-20, no effect)
    start_frame(0);
    while (cyc < 24) begin
      bus.stall = ((cyc + 1 >= 4 && cyc + 1 <= 6) || (cyc + 1 >= 19 && cyc + 1 <= 20));
      cycle();
      if (cyc == 4) chk("st_c4_rd_en", bus.rd_en, 0);
      if (cyc == 6) chk("st_c6_hold_m", bus.rd_addr_m, 2);
      if (cyc == 7) begin
        chk("st_c7_rd_en", bus.rd_en, 1);
        chk("st_c7_rd_m", bus.rd_addr_m, 3);
      end
    end
    bus.stall = 1'b0;
    chk("st_rd_cnt", rd_cnt, 15);
    chk("st_rd_last", rd_last, 18);
    chk("st_done_cnt", done_cnt, 1);
    chk("st_done_cyc", qget(done_log, 0), 21);
    chk("st_busy_last", busy_last, 21);
    chk_seq("st", 12);

    // Start re-asserted mid-frame
    start_frame(0);
    while (cyc < 22) begin
      bus.start = (cyc + 1 >= 10 && cyc + 1 <= 12);
      cycle();
    end
    bus.start = 1'b0;
    chk("rs_rd_cnt", rd_cnt, 15);
    chk("rs_rd_last", rd_last, 15);
    chk("rs_done_cnt", done_cnt, 1);
    chk("rs_done_cyc", qget(done_log, 0), 18);
    chk_seq("rs", 12);

    // Asynchronous abort in cycle 8
    start_frame(0);
    while (cyc < 8) cycle();
    chk("ab_pre_busy", bus.busy, 1);
    #1 rst = 1'b1;
    #1 chk_zero("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    repeat (3) cycle();
    chk("ab_done_cnt", done_cnt, 0);
    chk("ab_busy_after", busy_last, 0);
    start_frame(0);
    while (cyc < 22) cycle();
    chk("ab_done_cyc", qget(done_log, 0), 18);
    chk("ab_rd_first", rd_first, 1);
    chk_seq("ab", 12);

    // Start held high: frames repeat every 19 cycles
    start_frame(1);
    while (cyc < 60) cycle();
    chk("bb_rd_rise_cnt", rd_rise.size(), 4);
    chk("bb_rd_rise1", qget(rd_rise, 1), 20);
    chk("bb_rd_rise2", qget(rd_rise, 2), 39);
    chk("bb_rd_rise3", qget(rd_rise, 3), 58);
    chk("bb_done_cnt", done_cnt, 3);
    chk("bb_done0", qget(done_log, 0), 18);
    chk("bb_done1", qget(done_log, 1), 37);
    chk("bb_done2", qget(done_log, 2), 56);
    chk("bb_busy_fall0", qget(busy_fall, 0), 19);
    chk("bb_busy_fall1", qget(busy_fall, 1), 38);
    chk_seq("bb", 36);
    bus.start = 1'b0;
    begin
      int n = 0;
      while (bus.busy !== 1'b0 && n < 60) begin
        cycle();
        n++;
      end
    end
    chk("bb_drain_busy", bus.busy, 0);
    chk("bb_done_total", done_cnt, 4);
    repeat (2) cycle();
    chk("bb_idle_rd_en", bus.rd_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
